// File: rtl/ej_pkg.sv
// ej_pkg: flit field layout, type encodings, FSM states and saturating add for the ejection unit
package ej_pkg;
  localparam int PKTW = 36;
  localparam int VLD = 36;
  localparam int TYP_HI = 35;
  localparam int TYP_LO = 34;
  localparam int DST_HI = 33;
  localparam int DST_LO = 32;
  localparam int CNTW = 16;
  typedef enum logic [1:0] {T_HEAD = 2'd0, T_BODY = 2'd1, T_TAIL = 2'd2, T_SINGLE = 2'd3} typ_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} st_t;
  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] c, input logic [1:0] n);
    logic [CNTW:0] s;
    s = {1'b0, c} + {{(CNTW-1){1'b0}}, n};
    return s[CNTW] ? '1 : s[CNTW-1:0];
  endfunction
endpackage

// File: rtl/ej_fifo.sv
// ej_fifo: store-and-forward flit FIFO; host sees only [rd, cm), rollback rewinds wr to cm
module ej_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        rb,
  input  logic        cmt,
  input  logic        pop,
  input  logic [33:0] wd,
  output logic [33:0] rdat,
  output logic        valid,
  output logic        full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr, cm, rd, base, wr_n;
  logic [33:0] mem [DEPTH];
  assign base = rb ? cm : wr;
  assign wr_n = base + {{AW{1'b0}}, we};
  assign valid = rd != cm;
  assign full = (wr - rd) == (AW+1)'(DEPTH);
  assign rdat = mem[rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      cm <= '0;
      rd <= '0;
    end else begin
      wr <= wr_n;
      if (cmt) cm <= wr_n;
      if (pop && valid) rd <= rd + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (we) mem[base[AW-1:0]] <= wd;
endmodule

// File: rtl/ej.sv
// ej: ejection unit reassembling switch flits into whole packets for the host, with drop/error stats
module ej
  import ej_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PKTW:0]   i,
  output logic            o_valid,
  output logic [31:0]     o_data,
  output logic            o_first,
  output logic            o_last,
  input  logic            o_ready,
  output logic            full,
  output logic [CNTW-1:0] pkt_cnt,
  output logic [CNTW-1:0] drop_cnt,
  output logic [CNTW-1:0] err_cnt
);
  st_t st, nst;
  typ_t t;
  logic v, hs, ends, mis, we, rb, cmt, p, d;
  logic [1:0] e;
  logic [33:0] rdat;
  assign v = i[VLD];
  assign t = typ_t'(i[TYP_HI:TYP_LO]);
  assign hs = t == T_HEAD || t == T_SINGLE;
  assign ends = t == T_TAIL || t == T_SINGLE;
  assign mis = i[DST_HI:DST_LO] != 2'(PORT_ID);
  // Overflow is judged on pre-edge occupancy and wins over every other action outside DROP
  always_comb begin
    we = 1'b0;
    rb = 1'b0;
    cmt = 1'b0;
    p = 1'b0;
    d = 1'b0;
    e = 2'd0;
    nst = st;
    if (v) begin
      if (st == DROP && !hs) nst = (t == T_TAIL) ? IDLE : DROP;
      else if (full) begin
        rb = 1'b1;
        d = 1'b1;
        e = 2'(st == DROP);
        nst = ends ? IDLE : DROP;
      end else if (st == RECV && !hs) begin
        we = 1'b1;
        cmt = ends;
        p = ends;
        nst = ends ? IDLE : RECV;
      end else if (hs) begin
        we = 1'b1;
        rb = st == RECV;
        cmt = t == T_SINGLE;
        p = t == T_SINGLE;
        e = 2'(st != IDLE) + 2'(mis);
        nst = (t == T_HEAD) ? RECV : IDLE;
      end else e = 2'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      pkt_cnt <= '0;
      drop_cnt <= '0;
      err_cnt <= '0;
    end else begin
      st <= nst;
      pkt_cnt <= sat_add(pkt_cnt, {1'b0, p});
      drop_cnt <= sat_add(drop_cnt, {1'b0, d});
      err_cnt <= sat_add(err_cnt, e);
    end
  ej_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .we(we),
    .rb(rb),
    .cmt(cmt),
    .pop(o_ready),
    .wd({hs, ends, i[31:0]}),
    .rdat(rdat),
    .valid(o_valid),
    .full(full)
  );
  assign o_first = rdat[33];
  assign o_last = rdat[32];
  assign o_data = rdat[31:0];
endmodule

// File: tb/tb_ej.sv
// tb_ej: directed vector table, hand sequences and random traffic checked against a queue-based packet model
module tb_ej;
  localparam int DEPTH = 16;
  localparam int PID = 0;
  logic clk = 1'b0, rst = 1'b1, o_ready = 1'b0;
  logic [36:0] i = '0;
  logic o_valid, o_first, o_last, full;
  logic [31:0] o_data;
  logic [15:0] pkt_cnt, drop_cnt, err_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ej #(.PORT_ID(PID), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i(i), .o_valid(o_valid), .o_data(o_data), .o_first(o_first),
    .o_last(o_last), .o_ready(o_ready), .full(full), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
    .err_cnt(err_cnt)
  );
  localparam logic [36:0] NONE = '0;
  function automatic logic [36:0] mk(input int t, input int d, input logic [31:0] x);
    return {1'b1, 2'(t), 2'(d), x};
  endfunction
  function automatic int sat(input int x);
    return x > 65535 ? 65535 : x;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  // Packet-level model: committed flits, flits of the packet in flight, and a mode (0 idle, 1 recv, 2 drop)
  logic [33:0] comq[$];
  logic [33:0] pend[$];
  int mode, m_pkt, m_drop, m_err;
  task automatic model_reset();
    comq.delete();
    pend.delete();
    mode = 0;
    m_pkt = 0;
    m_drop = 0;
    m_err = 0;
  endtask
  task automatic model_step(input logic [36:0] f, input logic r);
    logic fl, hs;
    int t, mis;
    logic [33:0] e;
    fl = (comq.size() + pend.size()) == DEPTH;
    if (r && comq.size() > 0) void'(comq.pop_front());
    if (f[36]) begin
      t = int'(f[35:34]);
      hs = t == 0 || t == 3;
      mis = (int'(f[33:32]) != PID) ? 1 : 0;
      e = {hs, t == 2 || t == 3, f[31:0]};
      if (mode == 2 && !hs) begin
        if (t == 2) mode = 0;
      end else begin
        if (mode == 2) begin
          m_err++;
          mode = 0;
        end
        if (fl) begin
          pend.delete();
          m_drop++;
          mode = (t == 2 || t == 3) ? 0 : 2;
        end else begin
          if (mode == 1 && hs) begin
            pend.delete();
            m_err++;
            mode = 0;
          end
          if (mode == 1) begin
            pend.push_back(e);
            if (t == 2) begin
              foreach (pend[k]) comq.push_back(pend[k]);
              pend.delete();
              m_pkt++;
              mode = 0;
            end
          end else if (t == 0) begin
            pend.push_back(e);
            m_err += mis;
            mode = 1;
          end else if (t == 3) begin
            comq.push_back(e);
            m_pkt++;
            m_err += mis;
          end else m_err++;
        end
      end
    end
  endtask
  task automatic step(input logic [36:0] f, input logic r);
    i = f;
    o_ready = r;
    model_step(f, r);
    @(posedge clk);
    #1;
  endtask
  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(o_valid), 32'(comq.size() != 0));
    chk({tag, ".full"}, 32'(full), 32'((comq.size() + pend.size()) == DEPTH));
    chk({tag, ".pkt"}, 32'(pkt_cnt), sat(m_pkt));
    chk({tag, ".drop"}, 32'(drop_cnt), sat(m_drop));
    chk({tag, ".err"}, 32'(err_cnt), sat(m_err));
    if (comq.size() != 0) chk({tag, ".flit"}, {30'(0), o_first, o_last} ^ o_data, {30'(0), comq[0][33:32]} ^ comq[0][31:0]);
    if (comq.size() != 0) chk({tag, ".data"}, o_data, comq[0][31:0]);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    i = NONE;
    o_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask
  typedef struct {
    logic [36:0] f;
    logic r, v;
    logic [31:0] d;
    logic fi, la;
    int pk, dr, er;
  } vec_t;
  vec_t tv[17];
  int thr;
  initial begin
    tv[0]  = '{mk(3, 0, 32'hA5), 1'b0, 1'b1, 32'hA5, 1'b1, 1'b1, 1, 0, 0};
    tv[1]  = '{NONE,             1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1, 0, 0};
    tv[2]  = '{mk(0, 0, 32'h1),  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1, 0, 0};
    tv[3]  = '{mk(1, 0, 32'h2),  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1, 0, 0};
    tv[4]  = '{mk(2, 0, 32'h3),  1'b0, 1'b1, 32'h1,  1'b1, 1'b0, 2, 0, 0};
    tv[5]  = '{NONE,             1'b0, 1'b1, 32'h1,  1'b1, 1'b0, 2, 0, 0};
    tv[6]  = '{NONE,             1'b1, 1'b1, 32'h2,  1'b0, 1'b0, 2, 0, 0};
    tv[7]  = '{NONE,             1'b1, 1'b1, 32'h3,  1'b0, 1'b1, 2, 0, 0};
    tv[8]  = '{NONE,             1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2, 0, 0};
    tv[9]  = '{mk(1, 0, 32'h9),  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2, 0, 1};
    tv[10] = '{mk(0, 0, 32'h4),  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2, 0, 1};
    tv[11] = '{mk(1, 0, 32'h5),  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2, 0, 1};
    tv[12] = '{mk(0, 0, 32'h6),  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2, 0, 2};
    tv[13] = '{mk(2, 0, 32'h7),  1'b1, 1'b1, 32'h6,  1'b1, 1'b0, 3, 0, 2};
    tv[14] = '{NONE,             1'b1, 1'b1, 32'h7,  1'b0, 1'b1, 3, 0, 2};
    tv[15] = '{mk(3, 1, 32'h8),  1'b1, 1'b1, 32'h8,  1'b1, 1'b1, 4, 0, 3};
    tv[16] = '{NONE,             1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 4, 0, 3};
    do_reset();
    chk("rst.valid", 32'(o_valid), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.cnts", {pkt_cnt, drop_cnt | err_cnt}, 0);
    foreach (tv[n]) begin
      step(tv[n].f, tv[n].r);
      chk($sformatf("vec%0d.valid", n), 32'(o_valid), 32'(tv[n].v));
      if (tv[n].v) begin
        chk($sformatf("vec%0d.data", n), o_data, tv[n].d);
        chk($sformatf("vec%0d.first", n), 32'(o_first), 32'(tv[n].fi));
        chk($sformatf("vec%0d.last", n), 32'(o_last), 32'(tv[n].la));
      end
      chk($sformatf("vec%0d.pkt", n), 32'(pkt_cnt), tv[n].pk);
      chk($sformatf("vec%0d.drop", n), 32'(drop_cnt), tv[n].dr);
      chk($sformatf("vec%0d.err", n), 32'(err_cnt), tv[n].er);
      chk($sformatf("vec%0d.full", n), 32'(full), 0);
    end
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(mk(k == 0 ? 0 : (k == 19 ? 2 : 1), 0, 32'(k)), 1'b0);
      if (k == 15) chk("long.full_at16", 32'(full), 1);
      check_model("long");
    end
    chk("long.drop", 32'(drop_cnt), 1);
    chk("long.valid", 32'(o_valid), 0);
    chk("long.full_end", 32'(full), 0);
    for (int k = 0; k < 3; k++) step(mk(k, 0, 32'(k + 16'h100)), 1'b0);
    chk("after_long.pkt", 32'(pkt_cnt), 1);
    chk("after_long.valid", 32'(o_valid), 1);
    chk("after_long.data", o_data, 32'h100);
    step(mk(3, 0, 32'h11), 1'b0);
    step(mk(0, 0, 32'h12), 1'b0);
    for (int k = 0; k < 3; k++) step(mk(1, 0, 32'(k + 16'h13)), 1'b0);
    chk("pre_arst.valid", 32'(o_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid", 32'(o_valid), 0);
    chk("arst.full", 32'(full), 0);
    chk("arst.pkt", 32'(pkt_cnt), 0);
    chk("arst.drop", 32'(drop_cnt), 0);
    chk("arst.err", 32'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(mk(3, 0, 32'h22), 1'b0);
    chk("post_arst.valid", 32'(o_valid), 1);
    chk("post_arst.data", o_data, 32'h22);
    chk("post_arst.pkt", 32'(pkt_cnt), 1);
    do_reset();
    thr = 50;
    for (int n = 0; n < 3000; n++) begin
      int r, t;
      if (n % 250 == 0) thr = (n / 250) % 3 == 0 ? 5 : ((n / 250) % 3 == 1 ? 50 : 95);
      r = int'($urandom_range(0, 9));
      t = r < 2 ? 0 : (r < 7 ? 1 : (r < 9 ? 2 : 3));
      step($urandom_range(0, 99) < 85 ? mk(t, $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 3)) : PID, $urandom) : NONE,
           $urandom_range(0, 99) < thr);
      check_model("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
